// File: rtl/id_queue.sv
// RV32I decode stage: decodes each instruction word on entry and queues the results in a DEPTH-entry FIFO.
// Optional feature macro: ID_ILLEGAL_CHK_EN (stores a per-entry illegal-instruction flag).
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

module id_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        inst_valid_i,
    output logic                        inst_ready_o,
    input  logic [`INST_WIDTH-1:0]      inst_i,
    input  logic [`INST_ADDR_WIDTH-1:0] inst_addr_i,
    output logic                        dec_valid_o,
    input  logic                        dec_ready_i,
    output logic [`INST_WIDTH-1:0]      inst_o,
    output logic [`INST_ADDR_WIDTH-1:0] inst_addr_o,
    output logic [`REG_ADDR_WIDTH-1:0]  rs1_raddr_o,
    output logic [`REG_ADDR_WIDTH-1:0]  rs2_raddr_o,
    output logic [`REG_ADDR_WIDTH-1:0]  rd_waddr_o,
    output logic [`DATA_WIDTH-1:0]      imm_o,
    output logic [3:0]                  fmt_o,
    output logic                        illegal_o,
    output logic [PTR_W:0]              count_o
);

    logic [`INST_WIDTH-1:0]      r_inst [DEPTH];
    logic [`INST_ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [`REG_ADDR_WIDTH-1:0]  r_rd   [DEPTH];
    logic [`DATA_WIDTH-1:0]      r_imm  [DEPTH];
    logic [3:0]                  r_fmt  [DEPTH];
    logic [PTR_W-1:0]            r_wptr;
    logic [PTR_W-1:0]            r_rptr;
    logic [PTR_W:0]              r_count;

    logic                        w_push;
    logic                        w_pop;
    logic [3:0]                  w_fmt;
    logic [`REG_ADDR_WIDTH-1:0]  w_rd;
    logic [`DATA_WIDTH-1:0]      w_imm;
    logic [2:0]                  w_f3;
    logic [6:0]                  w_f7;

    assign inst_ready_o = (r_count < (PTR_W+1)'(DEPTH));
    assign dec_valid_o  = (r_count != '0);
    assign w_push       = inst_valid_i && inst_ready_o;
    assign w_pop        = dec_valid_o && dec_ready_i;
    assign w_f3         = inst_i[14:12];
    assign w_f7         = inst_i[31:25];

    // Decode of the incoming word; results are written into the entry alongside it.
    always_comb begin
        w_fmt = 4'd15;
        w_rd  = `ZERO_REG;
        w_imm = '0;
        case (inst_i[6:0])
            7'b0110111: begin w_fmt = 4'd0;  w_rd = inst_i[11:7]; w_imm = {inst_i[31:12], 12'b0}; end
            7'b0010111: begin w_fmt = 4'd1;  w_rd = inst_i[11:7]; w_imm = {inst_i[31:12], 12'b0}; end
            7'b1101111: begin
                w_fmt = 4'd2;
                w_rd  = inst_i[11:7];
                w_imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            end
            7'b1100111: begin w_fmt = 4'd3;  w_rd = inst_i[11:7]; w_imm = {{20{inst_i[31]}}, inst_i[31:20]}; end
            7'b1100011: begin
                w_fmt = 4'd4;
                w_imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            end
            7'b0000011: begin w_fmt = 4'd5;  w_rd = inst_i[11:7]; w_imm = {{20{inst_i[31]}}, inst_i[31:20]}; end
            7'b0100011: begin w_fmt = 4'd6;  w_imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]}; end
            7'b0010011: begin w_fmt = 4'd7;  w_rd = inst_i[11:7]; w_imm = {{20{inst_i[31]}}, inst_i[31:20]}; end
            7'b0110011: begin w_fmt = 4'd8;  w_rd = inst_i[11:7]; end
            7'b0001111: begin w_fmt = 4'd9;  end
            7'b1110011: begin w_fmt = 4'd10; w_rd = inst_i[11:7]; end
            default:    begin w_fmt = 4'd15; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_inst[i] <= '0;
                r_addr[i] <= '0;
                r_rd[i]   <= '0;
                r_imm[i]  <= '0;
                r_fmt[i]  <= '0;
            end
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_inst[r_wptr] <= inst_i;
                r_addr[r_wptr] <= inst_addr_i;
                r_rd[r_wptr]   <= w_rd;
                r_imm[r_wptr]  <= w_imm;
                r_fmt[r_wptr]  <= w_fmt;
                r_wptr         <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

`ifdef ID_ILLEGAL_CHK_EN
    logic r_ill [DEPTH];
    logic w_ill;

    always_comb begin
        w_ill = 1'b0;
        if (inst_i[1:0] != 2'b11 || w_fmt == 4'd15) begin
            w_ill = 1'b1;
        end else begin
            case (w_fmt)
                4'd3:  w_ill = (w_f3 != 3'd0);
                4'd4:  w_ill = (w_f3 == 3'd2) || (w_f3 == 3'd3);
                4'd5:  w_ill = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
                4'd6:  w_ill = (w_f3 > 3'd2);
                4'd7: begin
                    if (w_f3 == 3'd1)      w_ill = (w_f7 != 7'h00);
                    else if (w_f3 == 3'd5) w_ill = (w_f7 != 7'h00) && (w_f7 != 7'h20);
                    else                   w_ill = 1'b0;
                end
                4'd8:  w_ill = !((w_f7 == 7'h00) || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)));
                4'd10: w_ill = (w_f3 == 3'd4);
                default: w_ill = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_ill[i] <= 1'b0;
        end else if (!flush_i && w_push) begin
            r_ill[r_wptr] <= w_ill;
        end
    end

    assign illegal_o = r_ill[r_rptr];
`else
    assign illegal_o = 1'b0;
`endif

    assign inst_o      = r_inst[r_rptr];
    assign inst_addr_o = r_addr[r_rptr];
    assign rs1_raddr_o = r_inst[r_rptr][19:15];
    assign rs2_raddr_o = r_inst[r_rptr][24:20];
    assign rd_waddr_o  = r_rd[r_rptr];
    assign imm_o       = r_imm[r_rptr];
    assign fmt_o       = r_fmt[r_rptr];
    assign count_o     = r_count;

endmodule

// File: tb/tb_id_queue.sv
// Directed bench for id_queue: a scoreboard queue holds expected decoded entries in push order.
module tb_id_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        inst_valid_i;
    logic        inst_ready_o;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [4:0]  rs1_raddr_o;
    logic [4:0]  rs2_raddr_o;
    logic [4:0]  rd_waddr_o;
    logic [31:0] imm_o;
    logic [3:0]  fmt_o;
    logic        illegal_o;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [3:0]  fmt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ill;
    } entry_t;

    entry_t exp_q[$];
    int     m_count = 0;

`ifdef ID_ILLEGAL_CHK_EN
    localparam logic ILL_ON = 1'b1;
`else
    localparam logic ILL_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    id_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .rs1_raddr_o(rs1_raddr_o), .rs2_raddr_o(rs2_raddr_o),
        .rd_waddr_o(rd_waddr_o), .imm_o(imm_o), .fmt_o(fmt_o),
        .illegal_o(illegal_o), .count_o(count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check state against the model, drive inputs, advance the model.
    task automatic cyc(input logic push, input logic [31:0] inst, input logic [31:0] addr,
                       input logic [3:0] fmt, input logic [4:0] rd, input logic [31:0] imm,
                       input logic ill, input logic pop, input logic flush);
        entry_t e;
        logic   do_push;
        logic   do_pop;
        chk("count", 32'(count_o), 32'(m_count));
        chk("dec_valid", 32'(dec_valid_o), 32'(m_count != 0));
        chk("inst_ready", 32'(inst_ready_o), 32'(m_count < 4));
        if (m_count != 0) begin
            e = exp_q[0];
            chk("head_inst", inst_o, e.inst);
            chk("head_addr", inst_addr_o, e.addr);
            chk("head_fmt", 32'(fmt_o), 32'(e.fmt));
            chk("head_rd", 32'(rd_waddr_o), 32'(e.rd));
            chk("head_imm", imm_o, e.imm);
            chk("head_rs1", 32'(rs1_raddr_o), 32'(e.inst[19:15]));
            chk("head_rs2", 32'(rs2_raddr_o), 32'(e.inst[24:20]));
            chk("head_ill", 32'(illegal_o), 32'(e.ill));
        end
        do_push = push && (m_count < 4) && !flush;
        do_pop  = pop && (m_count != 0) && !flush;
        inst_valid_i = push;
        inst_i       = inst;
        inst_addr_i  = addr;
        dec_ready_i  = pop;
        flush_i      = flush;
        @(posedge clk);
        #1;
        inst_valid_i = 1'b0;
        dec_ready_i  = 1'b0;
        flush_i      = 1'b0;
        if (flush) begin
            exp_q.delete();
            m_count = 0;
        end else begin
            if (do_pop) begin
                void'(exp_q.pop_front());
                m_count--;
            end
            if (do_push) begin
                e.inst = inst; e.addr = addr; e.fmt = fmt; e.rd = rd; e.imm = imm; e.ill = ill;
                exp_q.push_back(e);
                m_count++;
            end
        end
    endtask

    // addi x(rd), x0, k: an always-legal OP-IMM with a small positive immediate.
    task automatic addi(input int k, input logic [31:0] addr, input logic pop);
        logic [31:0] w;
        w = {12'(k), 5'd0, 3'b000, 5'(k % 32), 7'h13};
        cyc(1'b1, w, addr, 4'd7, 5'(k % 32), 32'(k), 1'b0, pop, 1'b0);
    endtask

    task automatic idle(input logic pop);
        cyc(1'b0, 32'h0, 32'h0, 4'd0, 5'd0, 32'd0, 1'b0, pop, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && m_count != 0; i++) idle(1'b1);
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; inst_valid_i = 1'b0; dec_ready_i = 1'b0;
        inst_i = '0; inst_addr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_count", 32'(count_o), 32'h0);
        chk("rst_valid", 32'(dec_valid_o), 32'h0);
        chk("rst_ready", 32'(inst_ready_o), 32'h1);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_addr", inst_addr_o, 32'h0);
        chk("rst_fmt", 32'(fmt_o), 32'h0);
        chk("rst_imm", imm_o, 32'h0);
        chk("rst_rd", 32'(rd_waddr_o), 32'h0);
        chk("rst_rs1", 32'(rs1_raddr_o), 32'h0);
        chk("rst_rs2", 32'(rs2_raddr_o), 32'h0);
        chk("rst_ill", 32'(illegal_o), 32'h0);

        // addi x1,x0,-1 visible the cycle after the push
        cyc(1'b1, 32'hFFF00093, 32'h100, 4'd7, 5'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // fill to DEPTH with execute stalled, fifth offer refused, then drain in order
        for (int i = 1; i <= 4; i++) addi(i, 32'h200 + 32'(4 * i), 1'b0);
        addi(9, 32'h300, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);

        // sustained push+pop at count 2 across pointer wrap
        addi(20, 32'h400, 1'b0);
        addi(21, 32'h404, 1'b0);
        for (int i = 0; i < 10; i++) addi(22 + i, 32'h408 + 32'(4 * i), 1'b1);
        drain();

        // other encodings: sw, beq, lui, jal
        cyc(1'b1, 32'h0020A423, 32'h500, 4'd6, 5'd0, 32'h8, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hFE208EE3, 32'h504, 4'd4, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h123450B7, 32'h508, 4'd0, 5'd1, 32'h12345000, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'h008000EF, 32'h50C, 4'd2, 5'd1, 32'h8, 1'b0, 1'b1, 1'b0);
        drain();

        // flush with count 3 and a concurrent offer: offer is dropped
        for (int i = 0; i < 3; i++) addi(40 + i, 32'h600 + 32'(4 * i), 1'b0);
        cyc(1'b1, 32'h00100093, 32'h6F0, 4'd7, 5'd1, 32'h1, 1'b0, 1'b1, 1'b1);
        chk("flush_count", 32'(count_o), 32'h0);
        chk("flush_valid", 32'(dec_valid_o), 32'h0);
        chk("flush_ready", 32'(inst_ready_o), 32'h1);
        addi(50, 32'h700, 1'b0);
        drain();

        // illegal detection
        cyc(1'b1, 32'h0000707F, 32'h800, 4'd15, 5'd0, 32'h0, ILL_ON, 1'b0, 1'b0);
        cyc(1'b1, 32'h40001033, 32'h804, 4'd8, 5'd0, 32'h0, ILL_ON, 1'b0, 1'b0);
        cyc(1'b1, 32'h40005033, 32'h808, 4'd8, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        drain();
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/id_queue.md
# id_queue

Parametrised decode stage that follows fetch. It accepts raw RV32I instruction words through a valid/ready handshake, decodes each one at entry, and holds the decoded results in a DEPTH-entry FIFO. The FIFO lets fetch run ahead while execute stalls. Decoded entries go to execute through a second valid/ready handshake, and a flush input discards everything in flight on a redirect.

## Interface
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- PTR_W, 2: log2(DEPTH).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush_i  in  1  discard all queued entries.
- inst_valid_i  in  1  fetch presents an instruction.
- inst_ready_o  out  1  queue can accept an instruction.
- inst_i  in  `INST_WIDTH  raw instruction word.
- inst_addr_i  in  `INST_ADDR_WIDTH  instruction address.
- dec_valid_o  out  1  head entry is valid.
- dec_ready_i  in  1  execute consumes the head entry.
- inst_o  out  `INST_WIDTH  raw word of the head entry.
- inst_addr_o  out  `INST_ADDR_WIDTH  address of the head entry.
- rs1_raddr_o, rs2_raddr_o  out  `REG_ADDR_WIDTH  inst[19:15] and inst[24:20].
- rd_waddr_o  out  `REG_ADDR_WIDTH  inst[11:7] for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP and SYSTEM; `ZERO_REG for all other classes.
- imm_o  out  `DATA_WIDTH  sign-extended immediate.
- fmt_o  out  4  instruction class code (see Operation).
- illegal_o  out  1  head entry is an illegal instruction.
- count_o  out  PTR_W+1  number of occupied entries.

## Operation
- Push: when inst_valid_i && inst_ready_o, decode inst_i combinationally and write it with inst_addr_i at the write pointer.
- inst_ready_o = (count < DEPTH). A push into a full queue is refused even if a pop happens in the same cycle.
- Pop: when dec_valid_o && dec_ready_i, advance the read pointer.
- dec_valid_o = (count != 0). All dec outputs are driven directly from the entry at the read pointer.
- Pointers are PTR_W bits and wrap from DEPTH-1 to 0.
- Count update rules:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop together: count unchanged.
- fmt_o encoding:
  - 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE.
  - 7 OP-IMM, 8 OP, 9 MISC-MEM, 10 SYSTEM.
  - 15 for any unknown opcode.
- imm_o by class:
  - U (LUI, AUIPC): {inst[31:12], 12'b0}.
  - J (JAL): sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - B (BRANCH): sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - I (JALR, LOAD, OP-IMM): sign-extended inst[31:20].
  - S (STORE): sign-extended {inst[31:25], inst[11:7]}.
  - all other classes: 0.
- Flush: when flush_i is high, both pointers and count clear at the next edge.
  - Flush wins over a push or pop in the same cycle, so the offered instruction is dropped.
  - dec_valid_o is low in the following cycle.
- Reset: pointers, count and all entry storage clear to 0.
  - After reset: dec_valid_o=0, inst_ready_o=1, count_o=0, illegal_o=0, fmt_o=0, and every data output reads 0.
  - Reset has priority over flush and over both handshakes.

## Timing
- Accept-to-visible latency is 1 cycle: an instruction pushed at edge N shows dec_valid_o=1 and its fields during cycle N+1 when the queue was empty before the push.
- Throughput is one push and one pop per cycle, sustained when 0 < count < DEPTH.
- No combinational path from inst_valid_i or inst_i to any dec output.
- No combinational path from dec_ready_i to inst_ready_o.
- Head outputs stay stable while dec_valid_o && !dec_ready_i.
- Flush asserted at edge N: queue is empty from cycle N+1, and inst_ready_o=1 in cycle N+1.

## Configuration
- ID_ILLEGAL_CHK_EN defined: illegal detection is decoded at push and stored per entry. illegal_o=1 for any of:
  - inst[1:0] != 2'b11, or fmt 15.
  - JALR with funct3 != 0.
  - BRANCH with funct3 of 2 or 3.
  - LOAD with funct3 of 3, 6 or 7.
  - STORE with funct3 > 2.
  - SLLI, SRLI or SRAI with funct7 other than 0x00 (or 0x20 for SRLI/SRAI).
  - OP with funct7 other than 0x00, or 0x20 where funct3 is 0 or 5.
  - SYSTEM with funct3 = 4.
- Illegal entries otherwise queue and pop normally.
- ID_ILLEGAL_CHK_EN undefined: illegal_o is tied to 0 and no check logic is built; fmt_o still reports 15 for unknown opcodes.

## Test plan
- Reset, then push addi x1,x0,-1 (0xFFF00093) at addr 0x100 → next cycle: dec_valid_o=1, fmt_o=7, rd_waddr_o=1, imm_o=0xFFFFFFFF, inst_addr_o=0x100.
- Hold dec_ready_i=0 and push DEPTH=4 instructions → count_o=4, inst_ready_o=0, and a fifth offer is not accepted; then pop all four → they come out in order, and after the fourth pop dec_valid_o=0 and count_o=0.
- With count_o=2, push and pop in the same cycle for 10 cycles across pointer wrap → count_o stays 2 and the popped addresses are sequential.
- Push sw x2,8(x1) (0x0020A423) and beq x1,x2,-4 (0xFE208EE3) → fmt 6 with imm 8 and rd 0; then fmt 4 with imm 0xFFFFFFFC and rd 0.
- With count_o=3, assert flush_i and inst_valid_i together → next cycle count_o=0, dec_valid_o=0, and the offered instruction is dropped.
- With ID_ILLEGAL_CHK_EN defined, push 0x0000707F (opcode 0x7F) and 0x40001033 (OP with funct3 1, funct7 0x20) → both entries have illegal_o=1, and the first has fmt_o=15; without the macro, illegal_o=0 for both.
